// File: rtl/poly_audio_engine.sv
// rtl/poly_audio_engine.sv - multi-channel tone/noise generator with mixer, PWM and underflow irqs
module poly_audio_engine #(
  parameter int NUM_CH   = 4,
  parameter int DIV_W    = 8,
  parameter int PRE_FAST = 28,
  parameter int PRE_SLOW = 3333,
  parameter int ADDR_W   = $clog2(2 * NUM_CH + 3),
  parameter int MIX_W    = 4 + $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DIV_W-1:0]  wr_data,
  output logic [NUM_CH-1:0] wave,
  output logic [MIX_W-1:0]  mix,
  output logic              pwm,
  output logic              irq
);
  localparam int FW = $clog2(PRE_FAST + 1);
  localparam int SW = $clog2(PRE_SLOW + 1);
  localparam int NP = NUM_CH / 2;
  localparam int CW = 2 * DIV_W;

  logic [DIV_W-1:0]  freq    [NUM_CH];
  logic [7:0]        ctrl    [NUM_CH];
  logic [DIV_W-1:0]  cnt     [NUM_CH];
  logic [DIV_W-1:0]  cntNext [NUM_CH];
  logic [3:0]        gctl;
  logic [NUM_CH-1:0] irqEn, pend, ackBits;
  logic [FW-1:0]     preFast;
  logic [SW-1:0]     preSlow;
  logic [1:0]        quarter;
  logic              fastTick, slowTick, baseTick;
  logic [3:0]        p4;
  logic [4:0]        p5;
  logic [16:0]       p17;
  logic              p17Bit;
  logic              linkPrev, link, relink;
  logic [NUM_CH-1:0] srcTick, underflow, noiseBit, tone, smp;
  logic [CW-1:0]     pairCnt;
  logic [MIX_W-1:0]  mixSum, pcnt;

  // Register file: decode write strobes into frequency, control and global registers
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < NUM_CH; i++) begin
        freq[i] <= '0;
        ctrl[i] <= '0;
      end
      gctl  <= '0;
      irqEn <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_addr == ADDR_W'(2 * i))     freq[i] <= wr_data;
        if (wr_addr == ADDR_W'(2 * i + 1)) ctrl[i] <= wr_data[7:0];
      end
      if (wr_addr == ADDR_W'(2 * NUM_CH))     gctl  <= wr_data[3:0];
      if (wr_addr == ADDR_W'(2 * NUM_CH + 1)) irqEn <= wr_data[NUM_CH-1:0];
    end
  end

  assign ackBits  = (wr_en && wr_addr == ADDR_W'(2 * NUM_CH + 2)) ? wr_data[NUM_CH-1:0] : '0;
  assign fastTick = (preFast == FW'(PRE_FAST));
  assign slowTick = (preSlow == SW'(PRE_SLOW));
  assign baseTick = gctl[0] ? slowTick : (fastTick && quarter == 2'd3);
  assign link     = gctl[3];
  assign relink   = link ^ linkPrev;
  assign p17Bit   = gctl[2] ? p17[8] : p17[16];

  // Free-running prescalers, the fast/4 divider and the link-change detector
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      preFast  <= '0;
      preSlow  <= '0;
      quarter  <= '0;
      linkPrev <= 1'b0;
    end else begin
      preFast  <= fastTick ? '0 : preFast + FW'(1);
      preSlow  <= slowTick ? '0 : preSlow + SW'(1);
      linkPrev <= link;
      if (fastTick) quarter <= quarter + 2'd1;
    end
  end

  // Polynomial counters step on every fast tick; XNOR feedback so all-zero is a live state
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      p4  <= '0;
      p5  <= '0;
      p17 <= '0;
    end else if (fastTick) begin
      p4 <= {p4[2:0], ~(p4[3] ^ p4[2])};
      p5 <= {p5[3:0], ~(p5[4] ^ p5[2])};
      if (gctl[2]) p17[8:0] <= {p17[7:0], ~(p17[8] ^ p17[4])};
      else         p17      <= {p17[15:0], ~(p17[16] ^ p17[11])};
    end
  end

  // Per-channel clock source and selected noise bit
  always_comb begin
    srcTick  = {NUM_CH{baseTick}};
    noiseBit = '0;
    if (gctl[1]) srcTick[0] = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      case (ctrl[i][7:5])
        3'b000:         noiseBit[i] = p5[4] & p17Bit;
        3'b001, 3'b011: noiseBit[i] = p5[4];
        3'b010:         noiseBit[i] = p4[3] & p5[4];
        3'b100:         noiseBit[i] = p17Bit;
        3'b110:         noiseBit[i] = p4[3];
        default:        noiseBit[i] = 1'b1;
      endcase
    end
  end

  // Divider next state: a link change zeroes every counter, linked pairs count as one wide counter
  always_comb begin
    underflow = '0;
    pairCnt   = '0;
    for (int i = 0; i < NUM_CH; i++) cntNext[i] = cnt[i];
    if (relink) begin
      for (int i = 0; i < NUM_CH; i++) cntNext[i] = '0;
    end else if (link) begin
      for (int k = 0; k < NP; k++) begin
        pairCnt = {cnt[2*k+1], cnt[2*k]};
        if (srcTick[2*k]) begin
          if (pairCnt == '0) begin
            {cntNext[2*k+1], cntNext[2*k]} = {freq[2*k+1], freq[2*k]};
            underflow[2*k+1] = 1'b1;
          end else begin
            {cntNext[2*k+1], cntNext[2*k]} = pairCnt - CW'(1);
          end
        end
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (srcTick[i]) begin
          if (cnt[i] == '0) begin
            cntNext[i]   = freq[i];
            underflow[i] = 1'b1;
          end else begin
            cntNext[i] = cnt[i] - DIV_W'(1);
          end
        end
      end
    end
  end

  // Counters, tone flip-flops and noise sample latched on each rising tone edge
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
      tone <= '0;
      smp  <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i] <= cntNext[i];
        if (underflow[i]) begin
          tone[i] <= ~tone[i];
          if (!tone[i]) smp[i] <= noiseBit[i];
        end
        if (link && (i % 2) == 0) tone[i] <= 1'b0;
      end
    end
  end

  assign wave = tone & smp;

  // Pending interrupts: a new underflow beats a simultaneous acknowledge
  always_ff @(posedge clk or posedge clr) begin
    if (clr) pend <= '0;
    else     pend <= (pend & ~ackBits) | underflow;
  end

  assign irq = |(pend & irqEn);

  // Volume mixer sum
  always_comb begin
    mixSum = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (wave[i] | ctrl[i][4]) mixSum = mixSum + MIX_W'(ctrl[i][3:0]);
  end

  // Registered mix and free-running PWM ramp
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      mix  <= '0;
      pcnt <= '0;
    end else begin
      mix  <= mixSum;
      pcnt <= pcnt + MIX_W'(1);
    end
  end

  assign pwm = (pcnt < mix);
endmodule
